// File: rtl/ex_result_tracker.sv
// ex_result_tracker
// Back end of the EX stage: holds the EX/MEM and MEM/WB pipeline registers,
// selects the write-back value, produces the forwarding selects for the EX
// operands, raises the load-use stall and keeps a saturating count of stall
// cycles.
module ex_result_tracker #(
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   hold,
  input  logic                   flush,
  input  logic [31:0]            ALUresult,
  input  logic [4:0]             RegDest,
  input  logic                   EX_RegWrite,
  input  logic                   EX_MemRead,
  input  logic                   EX_MemToReg,
  input  logic [4:0]             IDtoEX_Rs,
  input  logic [4:0]             IDtoEX_Rt,
  input  logic [4:0]             IFtoID_Rs,
  input  logic [4:0]             IFtoID_Rt,
  input  logic [31:0]            MEM_ReadData,
  output logic [31:0]            EXtoMEM_ALUresult,
  output logic [4:0]             EXtoMEM_Rd,
  output logic                   EXtoMEM_RegWrite,
  output logic                   EXtoMEM_MemRead,
  output logic [31:0]            WB_ALUresult,
  output logic [4:0]             WB_Rd,
  output logic                   WB_RegWrite,
  output logic [1:0]             ForwardA,
  output logic [1:0]             ForwardB,
  output logic                   Stall,
  output logic [STALL_CNT_W-1:0] stall_count
);

  // Operand select encodings; 2'b11 is never produced.
  localparam logic [1:0] FWD_REGFILE = 2'b00;
  localparam logic [1:0] FWD_WB      = 2'b01;
  localparam logic [1:0] FWD_EXMEM   = 2'b10;

  // EX/MEM register contents
  logic [31:0] exmem_result_q;
  logic [4:0]  exmem_rd_q;
  logic        exmem_reg_write_q;
  logic        exmem_mem_read_q;
  logic        exmem_mem_to_reg_q;

  // MEM/WB register contents
  logic [31:0] wb_result_q;
  logic [4:0]  wb_rd_q;
  logic        wb_reg_write_q;

  // Values each register would take on an un-held edge
  logic [31:0] exmem_result_d;
  logic [4:0]  exmem_rd_d;
  logic        exmem_reg_write_d;
  logic        exmem_mem_read_d;
  logic        exmem_mem_to_reg_d;
  logic [31:0] wb_result_d;
  logic [4:0]  wb_rd_d;
  logic        wb_reg_write_d;

  // Stall counter state
  logic [STALL_CNT_W-1:0] stall_count_q;
  logic                   stall_count_sat;
  logic                   stall_count_inc;

  // A source register is forwarded from the youngest producer that writes
  // it; register 0 is hard-wired to zero and therefore never forwarded.
  function automatic logic [1:0] forward_select(
    input logic [4:0] src,
    input logic [4:0] exmem_rd,
    input logic       exmem_we,
    input logic [4:0] wb_rd,
    input logic       wb_we
  );
    logic [1:0] sel;
    sel = FWD_REGFILE;
    if (exmem_we && (exmem_rd != 5'd0) && (exmem_rd == src)) begin
      sel = FWD_EXMEM;
    end else if (wb_we && (wb_rd != 5'd0) && (wb_rd == src)) begin
      sel = FWD_WB;
    end
    return sel;
  endfunction

  // Next EX/MEM contents: a flushed instruction becomes a bubble by losing
  // its control bits, while its data and destination ride along harmlessly.
  always_comb begin
    exmem_result_d     = ALUresult;
    exmem_rd_d         = RegDest;
    exmem_reg_write_d  = EX_RegWrite;
    exmem_mem_read_d   = EX_MemRead;
    exmem_mem_to_reg_d = EX_MemToReg;
    if (flush) begin
      exmem_reg_write_d  = 1'b0;
      exmem_mem_read_d   = 1'b0;
      exmem_mem_to_reg_d = 1'b0;
    end
  end

  // Next MEM/WB contents: loads write back memory data, everything else
  // writes back the ALU result carried through EX/MEM.
  always_comb begin
    wb_result_d    = exmem_mem_to_reg_q ? MEM_ReadData : exmem_result_q;
    wb_rd_d        = exmem_rd_q;
    wb_reg_write_d = exmem_reg_write_q;
  end

  // EX/MEM register: cleared by reset, frozen by hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      exmem_result_q     <= 32'd0;
      exmem_rd_q         <= 5'd0;
      exmem_reg_write_q  <= 1'b0;
      exmem_mem_read_q   <= 1'b0;
      exmem_mem_to_reg_q <= 1'b0;
    end else if (!hold) begin
      exmem_result_q     <= exmem_result_d;
      exmem_rd_q         <= exmem_rd_d;
      exmem_reg_write_q  <= exmem_reg_write_d;
      exmem_mem_read_q   <= exmem_mem_read_d;
      exmem_mem_to_reg_q <= exmem_mem_to_reg_d;
    end
  end

  // MEM/WB register: cleared by reset (dropping any pending write), frozen
  // by hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      wb_result_q    <= 32'd0;
      wb_rd_q        <= 5'd0;
      wb_reg_write_q <= 1'b0;
    end else if (!hold) begin
      wb_result_q    <= wb_result_d;
      wb_rd_q        <= wb_rd_d;
      wb_reg_write_q <= wb_reg_write_d;
    end
  end

  // Load-use hazard: a load in EX whose destination is read by the
  // instruction in ID must wait one cycle so the value can come from WB.
  always_comb begin
    Stall = EX_MemRead && EX_RegWrite && (RegDest != 5'd0) &&
            ((RegDest == IFtoID_Rs) || (RegDest == IFtoID_Rt));
  end

  // Operand forwarding selects for the instruction currently in EX.
  always_comb begin
    ForwardA = forward_select(IDtoEX_Rs, exmem_rd_q, exmem_reg_write_q,
                              wb_rd_q, wb_reg_write_q);
    ForwardB = forward_select(IDtoEX_Rt, exmem_rd_q, exmem_reg_write_q,
                              wb_rd_q, wb_reg_write_q);
  end

  // Count only stall cycles that actually advance the pipe, and stop at
  // all-ones rather than wrapping.
  always_comb begin
    stall_count_sat = &stall_count_q;
    stall_count_inc = Stall && !hold && !stall_count_sat;
  end

  // Stall counter: cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_count_q <= '0;
    end else if (stall_count_inc) begin
      stall_count_q <= stall_count_q + STALL_CNT_W'(1);
    end
  end

  // Registered state straight to the outputs.
  always_comb begin
    EXtoMEM_ALUresult = exmem_result_q;
    EXtoMEM_Rd        = exmem_rd_q;
    EXtoMEM_RegWrite  = exmem_reg_write_q;
    EXtoMEM_MemRead   = exmem_mem_read_q;
    WB_ALUresult      = wb_result_q;
    WB_Rd             = wb_rd_q;
    WB_RegWrite       = wb_reg_write_q;
    stall_count       = stall_count_q;
  end

endmodule

// File: tb/tb_ex_result_tracker.sv
// tb_ex_result_tracker
// Directed-vector bench for ex_result_tracker. A second instance with a
// 2-bit stall counter shares all inputs so saturation can be observed.
module tb_ex_result_tracker;

  logic        clk = 1'b0;
  logic        reset;
  logic        hold;
  logic        flush;
  logic [31:0] ALUresult;
  logic [4:0]  RegDest;
  logic        EX_RegWrite;
  logic        EX_MemRead;
  logic        EX_MemToReg;
  logic [4:0]  IDtoEX_Rs;
  logic [4:0]  IDtoEX_Rt;
  logic [4:0]  IFtoID_Rs;
  logic [4:0]  IFtoID_Rt;
  logic [31:0] MEM_ReadData;

  logic [31:0] EXtoMEM_ALUresult;
  logic [4:0]  EXtoMEM_Rd;
  logic        EXtoMEM_RegWrite;
  logic        EXtoMEM_MemRead;
  logic [31:0] WB_ALUresult;
  logic [4:0]  WB_Rd;
  logic        WB_RegWrite;
  logic [1:0]  ForwardA;
  logic [1:0]  ForwardB;
  logic        Stall;
  logic [15:0] stall_count;

  logic [31:0] s_EXtoMEM_ALUresult;
  logic [4:0]  s_EXtoMEM_Rd;
  logic        s_EXtoMEM_RegWrite;
  logic        s_EXtoMEM_MemRead;
  logic [31:0] s_WB_ALUresult;
  logic [4:0]  s_WB_Rd;
  logic        s_WB_RegWrite;
  logic [1:0]  s_ForwardA;
  logic [1:0]  s_ForwardB;
  logic        s_Stall;
  logic [1:0]  s_stall_count;

  int assertCount = 0;
  int failCount   = 0;
  int expStall    = 0;
  int expStallSat = 0;

  always #5 clk = ~clk;

  ex_result_tracker dut (
    .clk(clk), .reset(reset), .hold(hold), .flush(flush),
    .ALUresult(ALUresult), .RegDest(RegDest),
    .EX_RegWrite(EX_RegWrite), .EX_MemRead(EX_MemRead), .EX_MemToReg(EX_MemToReg),
    .IDtoEX_Rs(IDtoEX_Rs), .IDtoEX_Rt(IDtoEX_Rt),
    .IFtoID_Rs(IFtoID_Rs), .IFtoID_Rt(IFtoID_Rt),
    .MEM_ReadData(MEM_ReadData),
    .EXtoMEM_ALUresult(EXtoMEM_ALUresult), .EXtoMEM_Rd(EXtoMEM_Rd),
    .EXtoMEM_RegWrite(EXtoMEM_RegWrite), .EXtoMEM_MemRead(EXtoMEM_MemRead),
    .WB_ALUresult(WB_ALUresult), .WB_Rd(WB_Rd), .WB_RegWrite(WB_RegWrite),
    .ForwardA(ForwardA), .ForwardB(ForwardB), .Stall(Stall),
    .stall_count(stall_count)
  );

  ex_result_tracker #(.STALL_CNT_W(2)) dutSat (
    .clk(clk), .reset(reset), .hold(hold), .flush(flush),
    .ALUresult(ALUresult), .RegDest(RegDest),
    .EX_RegWrite(EX_RegWrite), .EX_MemRead(EX_MemRead), .EX_MemToReg(EX_MemToReg),
    .IDtoEX_Rs(IDtoEX_Rs), .IDtoEX_Rt(IDtoEX_Rt),
    .IFtoID_Rs(IFtoID_Rs), .IFtoID_Rt(IFtoID_Rt),
    .MEM_ReadData(MEM_ReadData),
    .EXtoMEM_ALUresult(s_EXtoMEM_ALUresult), .EXtoMEM_Rd(s_EXtoMEM_Rd),
    .EXtoMEM_RegWrite(s_EXtoMEM_RegWrite), .EXtoMEM_MemRead(s_EXtoMEM_MemRead),
    .WB_ALUresult(s_WB_ALUresult), .WB_Rd(s_WB_Rd), .WB_RegWrite(s_WB_RegWrite),
    .ForwardA(s_ForwardA), .ForwardB(s_ForwardB), .Stall(s_Stall),
    .stall_count(s_stall_count)
  );

  // Compare one observed value against its expected value.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Drive every input, then let combinational outputs settle.
  task automatic applyStimulus(
    input logic        h,   input logic       f,
    input logic [31:0] alu, input logic [4:0] rd,
    input logic        rw,  input logic       mr, input logic m2r,
    input logic [4:0]  idRs, input logic [4:0] idRt,
    input logic [4:0]  ifRs, input logic [4:0] ifRt,
    input logic [31:0] rdata
  );
    hold = h; flush = f; ALUresult = alu; RegDest = rd;
    EX_RegWrite = rw; EX_MemRead = mr; EX_MemToReg = m2r;
    IDtoEX_Rs = idRs; IDtoEX_Rt = idRt; IFtoID_Rs = ifRs; IFtoID_Rt = ifRt;
    MEM_ReadData = rdata;
    #1;
  endtask

  // Advance one clock, sampling point just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Count a stall edge in both counter models.
  task automatic countStall();
    expStall++;
    if (expStallSat < 3) expStallSat++;
  endtask

  initial begin
    // Reset state with random, non-load inputs
    reset = 1'b1;
    applyStimulus(1'b0, $urandom_range(0, 1), $urandom, 5'($urandom),
                  $urandom_range(0, 1), 1'b0, $urandom_range(0, 1),
                  5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), $urandom);
    tick();
    applyStimulus(1'b0, $urandom_range(0, 1), $urandom, 5'($urandom),
                  $urandom_range(0, 1), 1'b0, $urandom_range(0, 1),
                  5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), $urandom);
    tick();
    checkOutput("rst_exmem_result", EXtoMEM_ALUresult, 32'd0);
    checkOutput("rst_exmem_rd", 32'(EXtoMEM_Rd), 32'd0);
    checkOutput("rst_exmem_rw", 32'(EXtoMEM_RegWrite), 32'd0);
    checkOutput("rst_exmem_mr", 32'(EXtoMEM_MemRead), 32'd0);
    checkOutput("rst_wb_result", WB_ALUresult, 32'd0);
    checkOutput("rst_wb_rd", 32'(WB_Rd), 32'd0);
    checkOutput("rst_wb_rw", 32'(WB_RegWrite), 32'd0);
    checkOutput("rst_fwdA", 32'(ForwardA), 32'd0);
    checkOutput("rst_fwdB", 32'(ForwardB), 32'd0);
    checkOutput("rst_stall", 32'(Stall), 32'd0);
    checkOutput("rst_stall_count", 32'(stall_count), 32'd0);
    checkOutput("rst_stall_count_sat", 32'(s_stall_count), 32'd0);

    reset = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();

    // Forwarding priority: two writes to r5, EX/MEM copy wins
    applyStimulus(0, 0, 32'h11, 5'd5, 1, 0, 0, 0, 0, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 32'h22, 5'd5, 1, 0, 0, 0, 0, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 5'd5, 5'd7, 0, 0, 0);
    checkOutput("prio_fwdA", 32'(ForwardA), 32'h2);
    checkOutput("prio_fwdB_nomatch", 32'(ForwardB), 32'h0);
    checkOutput("prio_exmem_result", EXtoMEM_ALUresult, 32'h22);
    checkOutput("prio_wb_result", WB_ALUresult, 32'h11);
    checkOutput("prio_wb_rd", 32'(WB_Rd), 32'd5);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 5'd5, 5'd5, 0, 0, 0);
    checkOutput("prio_fwdB", 32'(ForwardB), 32'h2);
    tick();
    checkOutput("wbpath_fwdA", 32'(ForwardA), 32'h1);
    checkOutput("wbpath_wb_result", WB_ALUresult, 32'h22);
    tick();
    checkOutput("drained_fwdA", 32'(ForwardA), 32'h0);

    // Register 0 is never a forwarding source
    applyStimulus(0, 0, 32'h33, 5'd0, 1, 0, 0, 0, 0, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("r0_exmem_rw", 32'(EXtoMEM_RegWrite), 32'd1);
    checkOutput("r0_fwdA_c1", 32'(ForwardA), 32'h0);
    checkOutput("r0_fwdB_c1", 32'(ForwardB), 32'h0);
    tick();
    checkOutput("r0_wb_rw", 32'(WB_RegWrite), 32'd1);
    checkOutput("r0_fwdA_c2", 32'(ForwardA), 32'h0);
    checkOutput("r0_fwdB_c2", 32'(ForwardB), 32'h0);

    // Load in EX whose destination is not read in ID: no stall
    applyStimulus(0, 0, 32'h80, 5'd8, 1, 1, 1, 0, 0, 5'd2, 5'd3, 0);
    checkOutput("load_nouse_stall", 32'(Stall), 32'd0);

    // Load-use stall and load data path
    applyStimulus(0, 0, 32'h100, 5'd8, 1, 1, 1, 0, 0, 5'd2, 5'd8, 0);
    checkOutput("lu_stall", 32'(Stall), 32'd1);
    tick();
    countStall();
    checkOutput("lu_stall_count", 32'(stall_count), 32'(expStall));
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'hCAFEF00D);
    checkOutput("lu_stall_clear", 32'(Stall), 32'd0);
    checkOutput("lu_exmem_mr", 32'(EXtoMEM_MemRead), 32'd1);
    checkOutput("lu_exmem_addr", EXtoMEM_ALUresult, 32'h100);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 5'd8, 0, 0, 0, 0);
    checkOutput("lu_wb_result", WB_ALUresult, 32'hCAFEF00D);
    checkOutput("lu_wb_rd", 32'(WB_Rd), 32'd8);
    checkOutput("lu_wb_rw", 32'(WB_RegWrite), 32'd1);
    checkOutput("lu_fwdA_wb", 32'(ForwardA), 32'h1);
    checkOutput("lu_stall_count_held", 32'(stall_count), 32'(expStall));

    // Flush turns the EX instruction into a bubble
    applyStimulus(0, 1, 32'h44, 5'd3, 1, 0, 0, 0, 0, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 5'd3, 5'd3, 0, 0, 0);
    checkOutput("flush_exmem_rw", 32'(EXtoMEM_RegWrite), 32'd0);
    checkOutput("flush_fwdA", 32'(ForwardA), 32'h0);
    checkOutput("flush_fwdB", 32'(ForwardB), 32'h0);

    // Hold freezes everything, even with flush and a stall present
    applyStimulus(0, 0, 32'h55, 5'd9, 1, 0, 0, 0, 0, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 32'h66, 5'd10, 1, 0, 0, 0, 0, 0, 0, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 1, 32'h70 + 32'(i), 5'd12, 1, 1, 1, 0, 0, 5'd12, 0,
                    32'hDEAD0000 + 32'(i));
      checkOutput("hold_stall", 32'(Stall), 32'd1);
      tick();
      checkOutput("hold_exmem_result", EXtoMEM_ALUresult, 32'h66);
      checkOutput("hold_exmem_rd", 32'(EXtoMEM_Rd), 32'd10);
      checkOutput("hold_exmem_rw", 32'(EXtoMEM_RegWrite), 32'd1);
      checkOutput("hold_wb_result", WB_ALUresult, 32'h55);
      checkOutput("hold_wb_rd", 32'(WB_Rd), 32'd9);
      checkOutput("hold_wb_rw", 32'(WB_RegWrite), 32'd1);
      checkOutput("hold_stall_count", 32'(stall_count), 32'(expStall));
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    checkOutput("unhold_wb_result", WB_ALUresult, 32'h66);
    checkOutput("unhold_wb_rw", 32'(WB_RegWrite), 32'd1);

    // Mid-stream reset drops the pending write-back
    reset = 1'b1;
    tick();
    reset = 1'b0;
    expStall = 0;
    expStallSat = 0;
    checkOutput("midrst_wb_rw", 32'(WB_RegWrite), 32'd0);
    checkOutput("midrst_stall_count", 32'(stall_count), 32'd0);

    // Saturation: five stall cycles on a 16-bit and a 2-bit counter
    applyStimulus(0, 0, 32'h4, 5'd4, 1, 1, 1, 0, 0, 5'd4, 0, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      countStall();
      checkOutput("sat_count_sat", 32'(s_stall_count), 32'(expStallSat));
    end
    checkOutput("sat_count_final", 32'(s_stall_count), 32'd3);
    checkOutput("sat_count_wide", 32'(stall_count), 32'd5);

    $display("End of test - %0d assertions evaluated, %0d failures",
             assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/ex_result_tracker.md
# ex_result_tracker

Back end of the EX stage interface. Captures each EX-stage result into the EX/MEM and MEM/WB pipeline registers, drives the forwarding data (`EXtoMEM_ALUresult`, `WB_ALUresult`) and the forwarding selects (`ForwardA`, `ForwardB`) consumed by the EX stage, and raises the load-use stall. It sits between the EX stage, data memory and the register-file write port.

## Interface
- `STALL_CNT_W`, default 16: width of the saturating load-use stall counter.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `hold`  in  1  freezes all pipeline registers (memory wait).
- `flush`  in  1  squashes the instruction currently in EX: it is captured as a bubble.
- `ALUresult`  in  32  EX-stage ALU result.
- `RegDest`  in  5  EX-stage destination register.
- `EX_RegWrite`, `EX_MemRead`, `EX_MemToReg`  in  1 each  EX-stage control bits.
- `IDtoEX_Rs`, `IDtoEX_Rt`  in  5 each  source registers of the instruction in EX.
- `IFtoID_Rs`, `IFtoID_Rt`  in  5 each  source registers of the instruction in ID.
- `MEM_ReadData`  in  32  data-memory read data, combinational from `EXtoMEM_ALUresult`.
- `EXtoMEM_ALUresult`  out  32  EX/MEM result; also the data-memory address.
- `EXtoMEM_Rd`  out  5  EX/MEM destination.
- `EXtoMEM_RegWrite`, `EXtoMEM_MemRead`  out  1 each.
- `WB_ALUresult`  out  32  write-back value, either load data or ALU result.
- `WB_Rd`  out  5  write-back destination.
- `WB_RegWrite`  out  1  register-file write enable.
- `ForwardA`, `ForwardB`  out  2 each  EX operand selects: 00 register file, 01 WB, 10 EX/MEM. 11 is never driven.
- `Stall`  out  1  load-use stall request to the IF/ID and PC logic.
- `stall_count`  out  `STALL_CNT_W`  number of cycles in which `Stall` was 1.

## Operation
- **EX/MEM register.** Each cycle it captures `ALUresult`, `RegDest`, `EX_RegWrite`, `EX_MemRead` and `EX_MemToReg`.
  - When `flush`=1, RegWrite, MemRead and MemToReg are captured as 0. Data and Rd are don't-care, but the implementation captures them anyway.
- **MEM/WB register.** Each cycle it captures:
  - `WB_ALUresult` = EX/MEM MemToReg ? `MEM_ReadData` : `EXtoMEM_ALUresult`.
  - `WB_Rd` = `EXtoMEM_Rd`.
  - `WB_RegWrite` = `EXtoMEM_RegWrite`.
- **Update priority:** reset > hold > flush > normal.
  - `hold`=1 keeps both registers and `stall_count` unchanged, even when `flush` is also 1.
- **ForwardA** (combinational, from registered state and `IDtoEX_Rs`):
  - 10 if `EXtoMEM_RegWrite`, `EXtoMEM_Rd`≠0 and `EXtoMEM_Rd`==`IDtoEX_Rs`.
  - Otherwise 01 if `WB_RegWrite`, `WB_Rd`≠0 and `WB_Rd`==`IDtoEX_Rs`.
  - Otherwise 00.
  - EX/MEM wins over WB when both match.
- **ForwardB:** same rules using `IDtoEX_Rt`.
- **Register $0** is never a forwarding source.
- **Stall** (combinational) = `EX_MemRead` & `EX_RegWrite` & (`RegDest`≠0) & (`RegDest`==`IFtoID_Rs` | `RegDest`==`IFtoID_Rt`).
  - This block does not insert the bubble. Upstream inserts it into ID/EX when `Stall`=1.
  - As a result, a load in EX/MEM is never forwarded from EX/MEM to a dependent instruction; the WB path supplies the value.
- **stall_count** increments by 1 on each edge where `Stall`=1 and `hold`=0.
  - It saturates at all-ones.
  - It clears only on reset.

## Timing
- **Reset values:** all EX/MEM and MEM/WB fields are 0, so `ForwardA`=`ForwardB`=00 after reset. `stall_count`=0. `Stall` follows its inputs.
- **Latency:**
  - An EX result appears on the `EXtoMEM_*` outputs 1 cycle after capture.
  - It appears on the `WB_*` outputs 2 cycles after capture.
  - Load data appears on `WB_ALUresult` 2 cycles after the load was in EX.
- **Combinational outputs:** `ForwardA`, `ForwardB` and `Stall` have zero-cycle latency and no internal state beyond the pipeline registers.
- **Reset asserted mid-stream:** both registers clear on the next edge, which drops any pending write-back (`WB_RegWrite`=0).
- **Simultaneous hold and flush:** hold wins. The flush is lost, so upstream must re-assert it after hold drops.
- **Self-forwarding:** a WB write and an EX/MEM match to the same register in the same cycle select 10.

## Test plan
- **Reset state:** assert `reset` for 2 cycles with random inputs.
  - Required: all outputs 0, `ForwardA`=`ForwardB`=00, `stall_count`=0.
- **Forwarding priority:**
  - Stimulus:
    - Cycle 0: EX `RegDest`=5, `ALUresult`=0x11, RegWrite=1.
    - Cycle 1: `RegDest`=5, `ALUresult`=0x22.
    - Cycle 2: `IDtoEX_Rs`=5.
  - Required in cycle 2: `ForwardA`=10, `EXtoMEM_ALUresult`=0x22, `WB_ALUresult`=0x11.
- **$0 is never forwarded:** RegWrite=1 with `RegDest`=0, then `IDtoEX_Rs`=`IDtoEX_Rt`=0.
  - Required: `ForwardA`=`ForwardB`=00 on both subsequent cycles.
- **Load-use stall and load data path:** EX holds a load (MemRead=1, MemToReg=1, `RegDest`=8) with `IFtoID_Rt`=8.
  - Required in that cycle: `Stall`=1, and `stall_count` increments by 1.
  - With `MEM_ReadData`=0xCAFEF00D in the next cycle, required 2 cycles after the load was in EX: `WB_ALUresult`=0xCAFEF00D, `WB_Rd`=8, `WB_RegWrite`=1.
- **Flush:** `flush`=1 with RegWrite=1, `RegDest`=3.
  - Required next cycle: `EXtoMEM_RegWrite`=0, and `ForwardA`=00 when `IDtoEX_Rs`=3.
- **Hold, flush and saturation:**
  - Assert `hold` for 3 cycles with changing inputs and `flush`=1. Required: all registered outputs unchanged.
  - With `STALL_CNT_W`=2, hold `Stall` high for 5 cycles. Required: `stall_count`=3.
